// File: rtl/sclk_frame_rx.sv
// sclk_frame_rx
// Receive side of the start/sclk serial framing link. start, sclk and sdin
// are synchronised into the clk domain. One bit is shifted in per
// synchronised sclk rising edge while start is held high. A complete
// DATA_W-bit word is presented on dout with a one-cycle dout_valid strobe.
// A start drop mid-frame, or surplus sclk edges after a full word, pulse
// frame_err.
module sclk_frame_rx #(
    parameter int DATA_W      = 4,
    parameter int SYNC_STAGES = 2,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              start,
    input  logic              sclk,
    input  logic              sdin,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int WARM   = SYNC_STAGES + 1;
    localparam int WARM_W = $clog2(WARM + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        WAIT_END = 2'd2
    } state_t;

    // Per-stage synchroniser bits, packed as {start, sclk, sdin}
    logic [SYNC_STAGES-1:0][2:0] r_sync;
    logic                        r_start_d;
    logic                        r_sclk_d;
    logic [WARM_W-1:0]           r_warm;
    state_t                      r_state;
    logic [CNT_W-1:0]            r_cnt;
    logic [DATA_W-1:0]           r_shift;
    logic [DATA_W-1:0]           r_dout;
    logic                        r_dout_valid;
    logic                        r_frame_err;
    logic                        r_busy;

    logic                        w_start_s;
    logic                        w_sclk_s;
    logic                        w_sdin_s;
    logic                        w_start_rise;
    logic                        w_sclk_rise;
    logic                        w_armed;
    logic                        w_last_bit;
    logic [DATA_W-1:0]           w_shift_next;

    assign w_start_s    = r_sync[SYNC_STAGES-1][2];
    assign w_sclk_s     = r_sync[SYNC_STAGES-1][1];
    assign w_sdin_s     = r_sync[SYNC_STAGES-1][0];
    assign w_start_rise = w_start_s & ~r_start_d;
    assign w_sclk_rise  = w_sclk_s & ~r_sclk_d;
    // Synchroniser flops clear on reset, so a pin already high at reset
    // shows up as a false rise while the chain refills; frames are only
    // accepted once the chain has reflected the real pin levels.
    assign w_armed      = (r_warm == WARM_W'(WARM));
    assign w_last_bit   = (r_cnt == CNT_W'(DATA_W - 1));

    // Bit ordering: first bit ends up in the MSB or in the LSB of the word
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shift_next = {r_shift[DATA_W-2:0], w_sdin_s};
        end else begin : g_lsb_first
            assign w_shift_next = {w_sdin_s, r_shift[DATA_W-1:1]};
        end
    endgenerate

    // Synchronise the three async inputs and keep one delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync    <= '0;
            r_start_d <= 1'b0;
            r_sclk_d  <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], {start, sclk, sdin}};
            r_start_d <= w_start_s;
            r_sclk_d  <= w_sclk_s;
        end
    end

    // Count clk cycles after reset until the synchroniser output is trustworthy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_warm <= '0;
        end else if (!w_armed) begin
            r_warm <= r_warm + WARM_W'(1);
        end
    end

    // Frame FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_dout_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (en && w_start_rise && w_armed) begin
                        r_state <= SHIFT;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (!en) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else if (!w_start_s) begin
                        // Start dropped before the word completed; a bit
                        // arriving in the same cycle is not accepted.
                        r_frame_err <= 1'b1;
                        r_state     <= IDLE;
                        r_cnt       <= '0;
                        r_busy      <= 1'b0;
                    end else if (w_sclk_rise) begin
                        r_shift <= w_shift_next;
                        if (w_last_bit) begin
                            r_dout       <= w_shift_next;
                            r_dout_valid <= 1'b1;
                            r_cnt        <= '0;
                            r_state      <= WAIT_END;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                WAIT_END: begin
                    if (!w_start_s || !en) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_sclk_rise) begin
                        // Initiator clocked more bits than the word holds
                        r_frame_err <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign frame_err  = r_frame_err;
    assign busy       = r_busy;

endmodule

// File: tb/tb_sclk_frame_rx.sv
// Testbench for sclk_frame_rx. Two instances share the serial inputs: one
// MSB-first, one LSB-first. Stimulus pushes expected output events into a
// per-instance scoreboard queue; a monitor pops and compares whenever an
// instance strobes dout_valid or frame_err.
module tb_sclk_frame_rx;

    typedef struct {
        bit         is_err;
        logic [3:0] data;
    } ev_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic       start;
    logic       sclk;
    logic       sdin;
    logic [3:0] m_dout  [2];
    logic       m_valid [2];
    logic       m_err   [2];
    logic       m_busy  [2];

    ev_t        sb_q [2][$];
    ev_t        mon_e;
    int         n_checks;
    int         n_fail;
    bit         chk_no_busy;

    // Index 0: MSB first, index 1: LSB first
    sclk_frame_rx #(.DATA_W(4), .SYNC_STAGES(2), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .en(en), .start(start), .sclk(sclk), .sdin(sdin),
        .dout(m_dout[0]), .dout_valid(m_valid[0]), .frame_err(m_err[0]), .busy(m_busy[0])
    );

    sclk_frame_rx #(.DATA_W(4), .SYNC_STAGES(2), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .en(en), .start(start), .sclk(sclk), .sdin(sdin),
        .dout(m_dout[1]), .dout_valid(m_valid[1]), .frame_err(m_err[1]), .busy(m_busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare every output strobe against the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                if (m_valid[k] || m_err[k]) begin
                    n_checks++;
                    if (sb_q[k].size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_event dut%0d: valid=%0b err=%0b dout=%h, required no event",
                                 k, m_valid[k], m_err[k], m_dout[k]);
                    end else begin
                        mon_e = sb_q[k].pop_front();
                        if (m_err[k] !== mon_e.is_err || m_valid[k] !== !mon_e.is_err ||
                            m_dout[k] !== mon_e.data) begin
                            n_fail++;
                            $display("FAIL event dut%0d: valid=%0b err=%0b dout=%h, required valid=%0b err=%0b dout=%h",
                                     k, m_valid[k], m_err[k], m_dout[k], !mon_e.is_err, mon_e.is_err, mon_e.data);
                        end else begin
                            $display("ok   event dut%0d: %s dout=%h", k,
                                     mon_e.is_err ? "frame_err " : "dout_valid", m_dout[k]);
                        end
                    end
                end
                if (chk_no_busy) begin
                    n_checks++;
                    if (m_busy[k] !== 1'b0) begin
                        n_fail++;
                        $display("FAIL busy_while_disabled dut%0d: busy=%0b, required 0", k, m_busy[k]);
                    end
                end
            end
        end
    end

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end else begin
            $display("ok   %s = %h", name, act);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            check4($sformatf("%s_dout%0d", tag, k), m_dout[k], 4'h0);
            check4($sformatf("%s_flags%0d", tag, k), {1'b0, m_valid[k], m_err[k], m_busy[k]}, 4'h0);
        end
    endtask

    task automatic push_ev(input bit is_err, input logic [3:0] d_msb, input logic [3:0] d_lsb);
        ev_t e;
        e.is_err = is_err;
        e.data   = d_msb;
        sb_q[0].push_back(e);
        e.data   = d_lsb;
        sb_q[1].push_back(e);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        sdin = b;
        wait_clks(5);
        sclk = 1'b1;
        wait_clks(5);
        sclk = 1'b0;
    endtask

    task automatic start_frame();
        start = 1'b1;
        wait_clks(5);
    endtask

    task automatic end_frame();
        wait_clks(5);
        start = 1'b0;
        wait_clks(6);
    endtask

    // Full frame; bits[3] goes on the wire first
    task automatic frame(input logic [3:0] bits);
        start_frame();
        for (int i = 3; i >= 0; i--) send_bit(bits[i]);
        end_frame();
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        chk_no_busy = 1'b0;
        rst   = 1'b1;
        en    = 1'b1;
        start = 1'b0;
        sclk  = 1'b0;
        sdin  = 1'b0;
        wait_clks(3);
        check_idle_zero("reset");
        rst = 1'b0;
        wait_clks(5);

        // T1/T2: bits 1,0,1,1 -> B (MSB first), D (LSB first)
        push_ev(1'b0, 4'hB, 4'hD);
        start_frame();
        send_bit(1'b1);
        check4("busy_in_frame0", {3'b0, m_busy[0]}, 4'h1);
        check4("busy_in_frame1", {3'b0, m_busy[1]}, 4'h1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        end_frame();

        // T3: start drops after two bits -> frame_err, dout held
        push_ev(1'b1, 4'hB, 4'hD);
        start_frame();
        send_bit(1'b0);
        send_bit(1'b0);
        end_frame();

        // T4: full frame plus a surplus sclk edge, then frame 0,1,1,0
        push_ev(1'b0, 4'hB, 4'hD);
        push_ev(1'b1, 4'hB, 4'hD);
        start_frame();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        end_frame();
        push_ev(1'b0, 4'h6, 4'h6);
        frame(4'b0110);

        // T5: reset after three bits with start held high
        start_frame();
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        rst = 1'b1;
        wait_clks(1);
        rst = 1'b0;
        check_idle_zero("midreset");
        send_bit(1'b1);
        wait_clks(4);
        check4("busy_after_reset0", {3'b0, m_busy[0]}, 4'h0);
        check4("busy_after_reset1", {3'b0, m_busy[1]}, 4'h0);
        start = 1'b0;
        wait_clks(6);
        push_ev(1'b0, 4'h5, 4'hA);
        frame(4'b0101);

        // T6: disabled frame, then enable while start already high
        chk_no_busy = 1'b1;
        en = 1'b0;
        frame(4'b1111);
        start_frame();
        en = 1'b1;
        wait_clks(5);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        end_frame();
        chk_no_busy = 1'b0;
        check4("dout_after_disabled0", m_dout[0], 4'h5);
        check4("dout_after_disabled1", m_dout[1], 4'hA);
        push_ev(1'b0, 4'hF, 4'hF);
        frame(4'b1111);

        wait_clks(10);
        check4("sb_leftover0", 4'(sb_q[0].size()), 4'h0);
        check4("sb_leftover1", 4'(sb_q[1].size()), 4'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
